// File: rtl/risc_sequencer.sv
// risc_sequencer: instruction-cycle controller for the VeriRISC CPU.
// Steps through the eight fetch/execute phases and decodes the opcode into
// datapath strobes. Strobes are a combinational decode of the current state,
// so each strobe is valid in the same cycle as its phase.
//
// Ports:
//   clk      system clock, rising-edge
//   reset    synchronous, active-high reset
//   opcode   instruction opcode from the instruction register
//   zero     accumulator-is-zero flag
//   mem_rd   memory read strobe
//   mem_wr   memory write strobe
//   load_ir  instruction register load
//   load_ac  accumulator load
//   inc_pc   program counter increment (counter enable)
//   load_pc  program counter load (dominates inc_pc at the counter)
//   halt     processor halted indication
//   phase    current phase encoding (reads 4 while halted)
//
// Parameter HALT_STICKY: 1 = freeze in the halted state until reset,
//                        0 = pulse halt during OP_ADDR and keep sequencing.
module risc_sequencer #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  // Bit 3 is the halted flag; the low three bits are the phase. The halted
  // encoding carries phase 4 so the phase output needs no extra muxing.
  typedef enum logic [3:0] {
    StInstAddr  = 4'h0,
    StInstFetch = 4'h1,
    StInstLoad  = 4'h2,
    StIdle      = 4'h3,
    StOpAddr    = 4'h4,
    StOpFetch   = 4'h5,
    StAluOp     = 4'h6,
    StStore     = 4'h7,
    StHalted    = 4'hC
  } state_e;

  state_e state_q, state_d;
  logic   is_aluop;

  assign is_aluop = (opcode == OpAdd) || (opcode == OpAnd) ||
                    (opcode == OpXor) || (opcode == OpLda);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInstAddr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StInstAddr;
    unique case (state_q)
      StInstAddr:  state_d = StInstFetch;
      StInstFetch: state_d = StInstLoad;
      StInstLoad:  state_d = StIdle;
      StIdle:      state_d = StOpAddr;
      StOpAddr:    state_d = (HALT_STICKY && (opcode == OpHlt)) ? StHalted : StOpFetch;
      StOpFetch:   state_d = StAluOp;
      StAluOp:     state_d = StStore;
      StStore:     state_d = StInstAddr;
      StHalted:    state_d = StHalted;
      // Unreachable encodings recover to the start of an instruction.
      default:     state_d = StInstAddr;
    endcase
  end

  // Output decode. The fetch phases never look at opcode, so an unknown
  // opcode before the IR is loaded cannot reach the strobes.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    halt    = 1'b0;
    phase   = state_q[2:0];
    unique case (state_q)
      StInstAddr: begin
      end
      StInstFetch: begin
        mem_rd = 1'b1;
      end
      StInstLoad, StIdle: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      StOpAddr: begin
        inc_pc = 1'b1;
        halt   = (opcode == OpHlt);
      end
      StOpFetch: begin
        mem_rd = is_aluop;
      end
      StAluOp: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OpSkz) && zero;
        load_pc = (opcode == OpJmp);
      end
      StStore: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OpJmp);
        load_pc = (opcode == OpJmp);
        mem_wr  = (opcode == OpSto);
      end
      StHalted: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: begin
        phase = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: one sticky-halt and one pulsed-halt instance
// driven from shared inputs, checked cycle by cycle against a phase model.
module tb_risc_sequencer;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;

  logic       mem_rd_a, mem_wr_a, load_ir_a, load_ac_a, inc_pc_a, load_pc_a, halt_a;
  logic [2:0] phase_a;
  logic       mem_rd_b, mem_wr_b, load_ir_b, load_ac_b, inc_pc_b, load_pc_b, halt_b;
  logic [2:0] phase_b;

  always #5 clk = ~clk;

  risc_sequencer #(.HALT_STICKY(1'b1)) u_sticky (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .load_ir(load_ir_a), .load_ac(load_ac_a),
    .inc_pc(inc_pc_a), .load_pc(load_pc_a), .halt(halt_a), .phase(phase_a)
  );

  risc_sequencer #(.HALT_STICKY(1'b0)) u_pulse (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .load_ir(load_ir_b), .load_ac(load_ac_b),
    .inc_pc(inc_pc_b), .load_pc(load_pc_b), .halt(halt_b), .phase(phase_b)
  );

  // {phase, halt, load_pc, inc_pc, load_ac, load_ir, mem_wr, mem_rd}
  logic [9:0] obs_a, obs_b;
  assign obs_a = {phase_a, halt_a, load_pc_a, inc_pc_a, load_ac_a, load_ir_a, mem_wr_a, mem_rd_a};
  assign obs_b = {phase_b, halt_b, load_pc_b, inc_pc_b, load_ac_b, load_ir_b, mem_wr_b, mem_rd_b};

  typedef struct {
    int         dut;
    logic [9:0] vec;
    string      tag;
  } sb_t;

  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int m_phase[2];
  bit m_halted[2];
  int inc_cnt_a;
  int halt_cnt_b;

  function automatic logic [9:0] model_out(int ph, bit hl, logic [2:0] op, logic z);
    logic rd, wr, ir, ac, inc, ldpc, hlt, alu;
    rd = 0; wr = 0; ir = 0; ac = 0; inc = 0; ldpc = 0; hlt = 0;
    if (hl) return {3'd4, 1'b1, 6'b0};
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    case (ph)
      1: rd = 1;
      2, 3: begin rd = 1; ir = 1; end
      4: begin inc = 1; hlt = (op == HLT); end
      5: rd = alu;
      6: begin rd = alu; ac = alu; inc = (op == SKZ) && z; ldpc = (op == JMP); end
      7: begin
        rd = alu; ac = alu; inc = (op == JMP); ldpc = (op == JMP); wr = (op == STO);
      end
      default: ;
    endcase
    return {3'(ph), hlt, ldpc, inc, ac, ir, wr, rd};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expectations, compare at negedge, advance model.
  task automatic cycle(input logic [2:0] op, input logic z, input logic rst, input string tag);
    sb_t e;
    opcode = op;
    zero   = z;
    reset  = rst;
    for (int d = 0; d < 2; d++) begin
      e.dut = d;
      e.vec = model_out(m_phase[d], m_halted[d], op, z);
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk);
    inc_cnt_a  += int'(inc_pc_a);
    halt_cnt_b += int'(halt_b);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("%s_dut%0d", e.tag, e.dut), (e.dut == 0) ? obs_a : obs_b, e.vec);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_phase[d] = 0; m_halted[d] = 0;
      end else if (!m_halted[d]) begin
        if (m_phase[d] == 4 && op == HLT && d == 0) m_halted[d] = 1;
        else m_phase[d] = (m_phase[d] + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic instr(input logic [2:0] op, input logic z, input string tag);
    for (int p = 0; p < 8; p++) cycle(op, z, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = ADD; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin m_phase[d] = 0; m_halted[d] = 0; end

    // Reset state plus a full ADD instruction and the wrap back to phase 0.
    cycle(ADD, 1'b0, 1'b0, "reset_state");
    for (int p = 1; p < 9; p++) cycle(ADD, 1'b0, 1'b0, "add");
    for (int p = 1; p < 8; p++) cycle(ADD, 1'b0, 1'b0, "add2");

    inc_cnt_a = 0;
    instr(SKZ, 1'b1, "skz_z1");
    chk_int("skz_z1_inc_count", inc_cnt_a, 2);
    inc_cnt_a = 0;
    instr(SKZ, 1'b0, "skz_z0");
    chk_int("skz_z0_inc_count", inc_cnt_a, 1);

    instr(JMP, 1'b0, "jmp");
    instr(STO, 1'b1, "sto");

    // Unknown opcode during the fetch phases must not reach the strobes.
    for (int p = 0; p < 4; p++) cycle(3'bxxx, 1'b0, 1'b0, "x_fetch");
    for (int p = 4; p < 8; p++) cycle(LDA, 1'b0, 1'b0, "lda");

    // Reset while in phase 6 of an LDA.
    for (int p = 0; p < 6; p++) cycle(LDA, 1'b0, 1'b0, "lda_pre_rst");
    cycle(LDA, 1'b0, 1'b1, "lda_rst_in_ph6");
    cycle(ADD, 1'b0, 1'b0, "after_rst");
    for (int p = 1; p < 8; p++) cycle(ADD, 1'b1, 1'b0, "resume");

    // HLT: sticky instance freezes, pulsed instance pulses once and continues.
    halt_cnt_b = 0;
    for (int p = 0; p < 5; p++) cycle(HLT, 1'b0, 1'b0, "hlt");
    chk("sticky_halted", obs_a, {3'd4, 1'b1, 6'b0});
    chk_int("pulse_phase_after_hlt", int'(phase_b), 5);
    for (int p = 0; p < 20; p++) cycle(ADD, 1'($urandom_range(0, 1)), 1'b0, "halted_hold");
    chk_int("pulse_halt_count", halt_cnt_b, 1);
    cycle(ADD, 1'b0, 1'b1, "halted_rst");
    cycle(ADD, 1'b0, 1'b0, "post_halt_rst");
    for (int p = 1; p < 8; p++) cycle(ADD, 1'b0, 1'b0, "post_halt_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
